sd_rw_checker: RTL and testbench

Synthesisable SD-card sector write/read-back self-test engine driving `sd_ctrl` over its native write/read handshake. It writes `NUM_SEC` consecutive sectors starting at `START_ADDR` with a generated pattern, reads each sector back, compares it word by word, and reports pass, error count and progress. It sits between `sd_ctrl` and board status logic (LEDs/UART) and replaces manual write-then-verify bring-up.

---
 rtl/sd_chk_pkg.sv | 17 +
 rtl/sd_rw_checker_if.sv | 16 +
 rtl/sd_chk_patgen.sv | 38 +++
 rtl/sd_rw_checker.sv | 155 +++++++++++++++
 tb/tb_sd_rw_checker.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_chk_pkg.sv
// sd_chk_pkg: shared FSM states, LFSR constants and pattern selectors for sd_rw_checker.
package sd_chk_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_START,
        ST_WR_WAIT,
        ST_RD_START,
        ST_RD_WAIT,
        ST_NEXT,
        ST_DONE
    } state_e;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps of x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic PAT_INC  = 1'b0;
    localparam logic PAT_LFSR = 1'b1;
endpackage

// File: rtl/sd_rw_checker_if.sv
// sd_rw_checker_if: native sd_ctrl write/read handshake; master = checker, slave = sd_ctrl.
interface sd_rw_checker_if #(parameter int DATA_W = 16);
    logic              sd_init_done;
    logic              wr_start_en, wr_busy, wr_req;
    logic              rd_start_en, rd_busy, rd_val_en;
    logic [31:0]       wr_sec_addr, rd_sec_addr;
    logic [DATA_W-1:0] wr_data, rd_val_data;
    modport master(
        input  sd_init_done, wr_busy, wr_req, rd_busy, rd_val_en, rd_val_data,
        output wr_start_en, wr_sec_addr, wr_data, rd_start_en, rd_sec_addr
    );
    modport slave(
        output sd_init_done, wr_busy, wr_req, rd_busy, rd_val_en, rd_val_data,
        input  wr_start_en, wr_sec_addr, wr_data, rd_start_en, rd_sec_addr
    );
endinterface

// File: rtl/sd_chk_patgen.sv
// sd_chk_patgen: test-word generator (incrementing, or LFSR when SD_CHK_LFSR_EN is defined).
// init reseeds per run, sec_start rewinds the word index per sector, step advances one word.
module sd_chk_patgen
    import sd_chk_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int SEC_WORDS = 256
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic              init,
    input  logic              sec_start,
    input  logic              step,
    input  logic              mode,
    input  logic [15:0]       sec_idx,
    output logic [DATA_W-1:0] word
);
    logic [15:0]       idx_q, idx_d;
    logic [DATA_W-1:0] inc;
    assign idx_d = (init || sec_start) ? '0 : step ? idx_q + 16'd1 : idx_q;
    assign inc   = DATA_W'(sec_idx) * DATA_W'(SEC_WORDS) + DATA_W'(idx_q);
    always_ff @(posedge clk_ref or negedge rst_n)
        if (!rst_n) idx_q <= '0;
        else        idx_q <= idx_d;
`ifdef SD_CHK_LFSR_EN
    // The LFSR only reseeds at run start so the sequence runs on across sectors.
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = init ? LFSR_SEED : step ? {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]} : lfsr_q;
    assign word   = (mode == PAT_LFSR) ? DATA_W'(lfsr_q) : inc;
    always_ff @(posedge clk_ref or negedge rst_n)
        if (!rst_n) lfsr_q <= '0;
        else        lfsr_q <= lfsr_d;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign word        = inc;
`endif
endmodule

// File: rtl/sd_rw_checker.sv
// sd_rw_checker: writes NUM_SEC sectors via sd_ctrl, reads them back and counts mismatching words.
// Define SD_CHK_LFSR_EN to honour pattern_sel (LFSR pattern, DATA_W = 16 only).
module sd_rw_checker
    import sd_chk_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int SEC_WORDS  = 256,
    parameter int START_ADDR = 2000,
    parameter int NUM_SEC    = 1,
    parameter bit AUTO_START = 1'b1
) (
    input  logic            clk_ref,
    input  logic            rst_n,
    input  logic            start,
    input  logic            pattern_sel,
    sd_rw_checker_if.master sd,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     err_cnt,
    output logic [15:0]     sec_cnt
);
    localparam int CW = $clog2(SEC_WORDS + 1);
    state_e            state_q, state_d;
    logic [15:0]       sec_idx_q, sec_idx_d, err_cnt_q, err_cnt_d, sec_cnt_q, sec_cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic              over_q, over_d, len_err_q, len_err_d, abort_q, abort_d;
    logic              done_q, done_d, pass_q, pass_d, mode_q, mode_d;
    logic              init_q, wr_busy_q, rd_busy_q;
    logic              go, start_run, in_run, wr_step, rd_step, mismatch;
    logic [DATA_W-1:0] rd_exp;
    assign go        = sd.sd_init_done & (start | (AUTO_START & ~init_q));
    assign start_run = (state_q == ST_IDLE) && go;
    assign in_run    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign wr_step   = (state_q == ST_WR_WAIT) && sd.wr_req;
    // Words past the sector length are counted as a length error, never compared.
    assign rd_step   = (state_q == ST_RD_WAIT) && sd.rd_val_en && (rd_cnt_q != CW'(SEC_WORDS));
    assign mismatch  = rd_step && (sd.rd_val_data != rd_exp);
    always_comb begin
        state_d   = state_q;
        sec_idx_d = sec_idx_q;
        sec_cnt_d = sec_cnt_q;
        addr_d    = addr_q;
        len_err_d = len_err_q;
        abort_d   = abort_q;
        done_d    = done_q;
        pass_d    = pass_q;
        mode_d    = mode_q;
        rd_cnt_d  = rd_step ? rd_cnt_q + CW'(1) : rd_cnt_q;
        over_d    = over_q | ((state_q == ST_RD_WAIT) && sd.rd_val_en && !rd_step);
        err_cnt_d = (mismatch && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
        case (state_q)
            ST_IDLE: if (go) begin
                state_d   = ST_WR_START;
                sec_idx_d = '0;
                err_cnt_d = '0;
                sec_cnt_d = '0;
                len_err_d = 1'b0;
                abort_d   = 1'b0;
                done_d    = 1'b0;
                pass_d    = 1'b0;
                mode_d    = pattern_sel;
            end
            ST_WR_START: state_d = ST_WR_WAIT;
            ST_WR_WAIT:  state_d = (wr_busy_q & ~sd.wr_busy) ? ST_RD_START : ST_WR_WAIT;
            ST_RD_START: state_d = ST_RD_WAIT;
            ST_RD_WAIT:  state_d = (rd_busy_q & ~sd.rd_busy) ? ST_NEXT : ST_RD_WAIT;
            ST_NEXT: begin
                sec_cnt_d = sec_cnt_q + 16'd1;
                len_err_d = len_err_q | over_q | (rd_cnt_q != CW'(SEC_WORDS));
                state_d   = (sec_idx_q == 16'(NUM_SEC - 1)) ? ST_DONE : ST_WR_START;
                sec_idx_d = (sec_idx_q == 16'(NUM_SEC - 1)) ? sec_idx_q : sec_idx_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (in_run && init_q && !sd.sd_init_done) begin
            state_d = ST_DONE;
            abort_d = 1'b1;
        end
        if (state_d == ST_WR_START) addr_d = 32'(START_ADDR) + 32'(sec_idx_d);
        if (state_d == ST_RD_START) begin
            rd_cnt_d = '0;
            over_d   = 1'b0;
        end
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d = 1'b1;
            pass_d = (err_cnt_d == '0) && !len_err_d && !abort_d;
        end
    end
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sec_idx_q <= '0;
            err_cnt_q <= '0;
            sec_cnt_q <= '0;
            addr_q    <= '0;
            rd_cnt_q  <= '0;
            over_q    <= 1'b0;
            len_err_q <= 1'b0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            mode_q    <= 1'b0;
            init_q    <= 1'b0;
            wr_busy_q <= 1'b0;
            rd_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_idx_q <= sec_idx_d;
            err_cnt_q <= err_cnt_d;
            sec_cnt_q <= sec_cnt_d;
            addr_q    <= addr_d;
            rd_cnt_q  <= rd_cnt_d;
            over_q    <= over_d;
            len_err_q <= len_err_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            mode_q    <= mode_d;
            init_q    <= sd.sd_init_done;
            wr_busy_q <= sd.wr_busy;
            rd_busy_q <= sd.rd_busy;
        end
    end
    sd_chk_patgen #(.DATA_W(DATA_W), .SEC_WORDS(SEC_WORDS)) u_wr_gen (
        .clk_ref  (clk_ref),
        .rst_n    (rst_n),
        .init     (start_run),
        .sec_start(state_d == ST_WR_START),
        .step     (wr_step),
        .mode     (mode_q),
        .sec_idx  (sec_idx_q),
        .word     (sd.wr_data)
    );
    sd_chk_patgen #(.DATA_W(DATA_W), .SEC_WORDS(SEC_WORDS)) u_rd_gen (
        .clk_ref  (clk_ref),
        .rst_n    (rst_n),
        .init     (start_run),
        .sec_start(state_d == ST_RD_START),
        .step     (rd_step),
        .mode     (mode_q),
        .sec_idx  (sec_idx_q),
        .word     (rd_exp)
    );
    assign sd.wr_start_en = (state_q == ST_WR_START);
    assign sd.rd_start_en = (state_q == ST_RD_START);
    assign sd.wr_sec_addr = addr_q;
    assign sd.rd_sec_addr = addr_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign sec_cnt        = sec_cnt_q;
endmodule

// File: tb/tb_sd_rw_checker.sv
// tb_sd_rw_checker: directed bench for sd_rw_checker with a behavioural sd_ctrl (3 sectors per run).
module tb_sd_rw_checker;
    logic        clk_ref = 1'b0;
    logic        rst_n = 1'b0, start = 1'b0, pattern_sel = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_cnt, sec_cnt;
    int          total = 0, bad = 0;
    logic [15:0] mem [int];
    int          addr_log[$], wr_first[$];
    int          flip_sec = -1, short_sec = -1;
    bit          model_busy = 1'b0;
    int          exp_log[6] = '{2000, 12000, 2001, 12001, 2002, 12002};

    sd_rw_checker_if #(.DATA_W(16)) sd ();

    sd_rw_checker #(
        .DATA_W(16), .SEC_WORDS(256), .START_ADDR(2000), .NUM_SEC(3), .AUTO_START(1'b1)
    ) dut (
        .clk_ref(clk_ref), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
        .sd(sd), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .sec_cnt(sec_cnt)
    );

    always #5 clk_ref = ~clk_ref;

    // Ideal sd_ctrl: writes land in mem, reads replay mem with optional bit flip / short sector.
    initial begin
        int a, n;
        sd.wr_busy = 0; sd.wr_req = 0; sd.rd_busy = 0; sd.rd_val_en = 0; sd.rd_val_data = 0;
        forever begin
            @(negedge clk_ref);
            if (sd.wr_start_en === 1'b1) begin
                model_busy = 1;
                a = sd.wr_sec_addr;
                addr_log.push_back(a);
                repeat (2) @(negedge clk_ref);
                sd.wr_busy = 1;
                @(negedge clk_ref);
                for (int i = 0; i < 256; i++) begin
                    sd.wr_req = 1;
                    mem[a * 256 + i] = sd.wr_data;
                    if (i == 0) wr_first.push_back(int'(sd.wr_data));
                    @(negedge clk_ref);
                end
                sd.wr_req = 0;
                @(negedge clk_ref);
                sd.wr_busy = 0;
                model_busy = 0;
            end else if (sd.rd_start_en === 1'b1) begin
                model_busy = 1;
                a = sd.rd_sec_addr;
                addr_log.push_back(a + 10000);
                n = (a == short_sec) ? 255 : 256;
                repeat (2) @(negedge clk_ref);
                sd.rd_busy = 1;
                @(negedge clk_ref);
                for (int i = 0; i < n; i++) begin
                    sd.rd_val_en = 1;
                    sd.rd_val_data = mem.exists(a * 256 + i) ? mem[a * 256 + i] : 16'h0;
                    if (a == flip_sec && i == 17) sd.rd_val_data = sd.rd_val_data ^ 16'h0001;
                    @(negedge clk_ref);
                end
                sd.rd_val_en = 0;
                sd.rd_val_data = 0;
                @(negedge clk_ref);
                sd.rd_busy = 0;
                model_busy = 0;
            end
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        while (done !== 1'b1 && n < 6000) begin
            @(negedge clk_ref);
            n++;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic wait_model_idle(string tag);
        int n = 0;
        while (model_busy && n < 2000) begin
            @(negedge clk_ref);
            n++;
        end
        check(tag, 32'(model_busy), 0);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk_ref);
        start = 0;
    endtask

    task automatic check_log(string tag);
        check({tag, " log len"}, addr_log.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s log[%0d]", tag, i), (i < addr_log.size()) ? addr_log[i] : -1, exp_log[i]);
    endtask

    initial begin
        int n;
        sd.sd_init_done = 0;
        repeat (3) @(negedge clk_ref);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst pass", 32'(pass), 0);
        check("rst err_cnt", 32'(err_cnt), 0);
        check("rst sec_cnt", 32'(sec_cnt), 0);
        check("rst wr_start_en", 32'(sd.wr_start_en), 0);
        check("rst rd_start_en", 32'(sd.rd_start_en), 0);
        check("rst wr_sec_addr", sd.wr_sec_addr, 0);
        check("rst rd_sec_addr", sd.rd_sec_addr, 0);
        check("rst wr_data", 32'(sd.wr_data), 0);
        rst_n = 1;
        repeat (2) @(negedge clk_ref);
        check("idle before init", 32'(busy), 0);

        // auto start on sd_init_done rising edge, incrementing pattern
        sd.sd_init_done = 1;
        @(negedge clk_ref);
        check("auto busy", 32'(busy), 1);
        check("auto wr_start_en", 32'(sd.wr_start_en), 1);
        check("auto wr_sec_addr", sd.wr_sec_addr, 2000);
        wait_done("run1 done");
        check("run1 pass", 32'(pass), 1);
        check("run1 err_cnt", 32'(err_cnt), 0);
        check("run1 sec_cnt", 32'(sec_cnt), 3);
        check_log("run1");
        check("run1 sec0 first word", (wr_first.size() > 0) ? wr_first[0] : -1, 0);
        check("run1 sec1 first word", (wr_first.size() > 1) ? wr_first[1] : -1, 256);
        check("run1 sec2 first word", (wr_first.size() > 2) ? wr_first[2] : -1, 512);
        check("run1 sec0 last word", 32'(mem[2000 * 256 + 255]), 255);
        check("run1 sec2 last word", 32'(mem[2002 * 256 + 255]), 767);
        @(negedge clk_ref);
        check("run1 busy after done", 32'(busy), 0);
        repeat (5) @(negedge clk_ref);
        check("run1 done held", 32'(done), 1);
        check("run1 pass held", 32'(pass), 1);

        // bit 0 of word 17 of sector 2000 corrupted on read
        addr_log.delete(); wr_first.delete();
        flip_sec = 2000;
        pulse_start();
        check("run2 done cleared", 32'(done), 0);
        check("run2 busy", 32'(busy), 1);
        wait_done("run2 done");
        check("run2 err_cnt", 32'(err_cnt), 1);
        check("run2 pass", 32'(pass), 0);
        check("run2 sec_cnt", 32'(sec_cnt), 3);
        flip_sec = -1;
        repeat (2) @(negedge clk_ref);

        // sector 2001 returns only 255 words
        addr_log.delete(); wr_first.delete();
        short_sec = 2001;
        pulse_start();
        wait_done("run3 done");
        check("run3 pass", 32'(pass), 0);
        check("run3 err_cnt", 32'(err_cnt), 0);
        check("run3 sec_cnt", 32'(sec_cnt), 3);
        short_sec = -1;
        repeat (2) @(negedge clk_ref);

        // pattern_sel = 1: LFSR when built in, otherwise ignored
        addr_log.delete(); wr_first.delete();
        pattern_sel = 1;
        pulse_start();
        pattern_sel = 0;
        wait_done("run4 done");
        check("run4 pass", 32'(pass), 1);
`ifdef SD_CHK_LFSR_EN
        check("run4 lfsr word0", (wr_first.size() > 0) ? wr_first[0] : -1, 32'hACE1);
        check("run4 lfsr word1", 32'(mem[2000 * 256 + 1]), 32'h5670);
        check("run4 lfsr word2", 32'(mem[2000 * 256 + 2]), 32'hAB38);
`else
        check("run4 inc word0", (wr_first.size() > 0) ? wr_first[0] : -1, 0);
        check("run4 inc word1", 32'(mem[2000 * 256 + 1]), 1);
`endif
        repeat (2) @(negedge clk_ref);

        // reset in the middle of a sector write
        pulse_start();
        n = 0;
        while (sd.wr_busy !== 1'b1 && n < 100) begin
            @(negedge clk_ref);
            n++;
        end
        check("run5 wr_busy seen", 32'(sd.wr_busy), 1);
        repeat (10) @(negedge clk_ref);
        rst_n = 0;
        sd.sd_init_done = 0;
        @(negedge clk_ref);
        check("run5 rst busy", 32'(busy), 0);
        check("run5 rst done", 32'(done), 0);
        check("run5 rst wr_data", 32'(sd.wr_data), 0);
        check("run5 rst wr_sec_addr", sd.wr_sec_addr, 0);
        check("run5 rst err_cnt", 32'(err_cnt), 0);
        wait_model_idle("run5 model idle");
        rst_n = 1;
        repeat (2) @(negedge clk_ref);
        pulse_start();
        @(negedge clk_ref);
        check("start without init ignored", 32'(busy), 0);
        addr_log.delete(); wr_first.delete();
        start = 1;
        sd.sd_init_done = 1;
        @(negedge clk_ref);
        start = 0;
        check("run5 busy", 32'(busy), 1);
        wait_done("run5 done");
        check("run5 pass", 32'(pass), 1);
        check("run5 sec_cnt", 32'(sec_cnt), 3);
        check_log("run5");
        repeat (6) @(negedge clk_ref);
        check("run5 single run", 32'(busy), 0);

        // sd_init_done drops during the first read
        pulse_start();
        n = 0;
        while (sd.rd_busy !== 1'b1 && n < 1000) begin
            @(negedge clk_ref);
            n++;
        end
        check("run6 rd_busy seen", 32'(sd.rd_busy), 1);
        repeat (20) @(negedge clk_ref);
        sd.sd_init_done = 0;
        @(negedge clk_ref);
        check("run6 abort done", 32'(done), 1);
        check("run6 abort pass", 32'(pass), 0);
        check("run6 abort sec_cnt", 32'(sec_cnt), 0);
        wait_model_idle("run6 model idle");
        @(negedge clk_ref);
        check("run6 idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
